// File: rtl/complete_stage_if.sv
// Shared row types and the DISPATCH/ISSUE/RENAME/writeback bundle of the
// reorder-buffer completion stage.
package complete_stage_pkg;

    localparam int unsigned PREG_W = 6;
    localparam int unsigned XLEN   = 32;

    typedef struct packed {
        logic              valid;
        logic              RegWrite;
        logic              MemWrite;
        logic [PREG_W-1:0] PRegAddrDst;
        logic [XLEN-1:0]   data;
    } rob_row_struct;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] PRegAddrDst;
        logic [XLEN-1:0]   data;
    } complete_stage_struct;

endpackage

interface complete_stage_if;
    import complete_stage_pkg::*;

    rob_row_struct        i_rob_row           [0:1];
    complete_stage_struct i_complete_result   [0:2];
    rob_row_struct        o_complete_rob_rows [0:2];
    rob_row_struct        o_retire_rob_rows   [0:1];

    // Producer/consumer side: drives dispatch rows and FU results
    modport master (
        output i_rob_row,
        output i_complete_result,
        input  o_complete_rob_rows,
        input  o_retire_rob_rows
    );

    // Reorder buffer side
    modport slave (
        input  i_rob_row,
        input  i_complete_result,
        output o_complete_rob_rows,
        output o_retire_rob_rows
    );

endinterface

// File: rtl/complete_stage.sv
// Reorder buffer: in-order dual dispatch, tag-matched completion from three
// functional units, in-order dual retirement. All outputs registered.
module complete_stage
    import complete_stage_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    complete_stage_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(ROB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        rob_row_struct row;
        logic          complete;
    } rob_entry_t;

    rob_entry_t       entries_q [ROB_DEPTH];
    rob_entry_t       entries_d [ROB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    rob_row_struct    complete_rows_q [0:2];
    rob_row_struct    complete_rows_d [0:2];
    rob_row_struct    retire_rows_q   [0:1];
    rob_row_struct    retire_rows_d   [0:1];

    logic             ret_head;
    logic             ret_next;
    logic [1:0]       n_ret;
    logic [PTR_W-1:0] head_plus1;
    logic [2:0]       match_found;
    logic [PTR_W-1:0] match_idx [0:2];
    logic [PTR_W-1:0] search_idx;
    logic [CNT_W-1:0] free_slots;
    logic [PTR_W-1:0] write_idx;
    logic [1:0]       accepted;

    // Next-state: retire, completion search and dispatch, all from pre-edge state
    always_comb begin
        entries_d  = entries_q;
        search_idx = '0;
        write_idx  = tail_q;
        accepted   = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            complete_rows_d[i] = '0;
            match_idx[i]       = '0;
        end
        match_found = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            retire_rows_d[s] = '0;
        end

        // Retire: head first, second entry only behind a retiring head
        head_plus1 = head_q + PTR_W'(1);
        ret_head   = (count_q != '0) && entries_q[head_q].complete;
        ret_next   = ret_head && (count_q > CNT_W'(1)) && entries_q[head_plus1].complete;
        n_ret      = {1'b0, ret_head} + {1'b0, ret_next};
        if (ret_head) begin
            retire_rows_d[0]       = entries_q[head_q].row;
            retire_rows_d[0].valid = 1'b1;
        end
        if (ret_next) begin
            retire_rows_d[1]       = entries_q[head_plus1].row;
            retire_rows_d[1].valid = 1'b1;
        end

        // Completion: oldest occupied, not-yet-complete entry with a matching tag.
        // Retiring entries are already complete, so they are never targeted here.
        for (int unsigned i = 0; i < 3; i++) begin
            if (bus.i_complete_result[i].valid) begin
                for (int unsigned k = 0; k < ROB_DEPTH; k++) begin
                    search_idx = head_q + PTR_W'(k);
                    if (!match_found[i] && (CNT_W'(k) < count_q) &&
                        !entries_q[search_idx].complete &&
                        (entries_q[search_idx].row.PRegAddrDst == bus.i_complete_result[i].PRegAddrDst)) begin
                        match_found[i] = 1'b1;
                        match_idx[i]   = search_idx;
                    end
                end
            end
        end
        // Same entry claimed twice: lower result index keeps it
        for (int unsigned i = 1; i < 3; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                if (match_found[i] && match_found[j] && (match_idx[i] == match_idx[j])) begin
                    match_found[i] = 1'b0;
                end
            end
        end
        for (int unsigned i = 0; i < 3; i++) begin
            if (match_found[i]) begin
                entries_d[match_idx[i]].complete = 1'b1;
                entries_d[match_idx[i]].row.data = bus.i_complete_result[i].data;
                complete_rows_d[i]               = entries_d[match_idx[i]].row;
                complete_rows_d[i].valid         = 1'b1;
            end
        end

        // Dispatch: slots freed by this edge's retirement are usable immediately
        free_slots = CNT_W'(ROB_DEPTH) - count_q + CNT_W'(n_ret);
        for (int unsigned s = 0; s < 2; s++) begin
            if (bus.i_rob_row[s].valid && (CNT_W'(accepted) < free_slots)) begin
                entries_d[write_idx].row      = bus.i_rob_row[s];
                entries_d[write_idx].complete = 1'b0;
                write_idx                     = write_idx + PTR_W'(1);
                accepted                      = accepted + 2'd1;
            end
        end

        head_d  = head_q + PTR_W'(n_ret);
        tail_d  = tail_q + PTR_W'(accepted);
        count_d = count_q + CNT_W'(accepted) - CNT_W'(n_ret);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned e = 0; e < ROB_DEPTH; e++) begin
                entries_q[e] <= '0;
            end
            for (int unsigned i = 0; i < 3; i++) begin
                complete_rows_q[i] <= '0;
            end
            for (int unsigned s = 0; s < 2; s++) begin
                retire_rows_q[s] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int unsigned e = 0; e < ROB_DEPTH; e++) begin
                entries_q[e] <= entries_d[e];
            end
            for (int unsigned i = 0; i < 3; i++) begin
                complete_rows_q[i] <= complete_rows_d[i];
            end
            for (int unsigned s = 0; s < 2; s++) begin
                retire_rows_q[s] <= retire_rows_d[s];
            end
        end
    end

    assign bus.o_complete_rob_rows = complete_rows_q;
    assign bus.o_retire_rob_rows   = retire_rows_q;

endmodule

// File: tb/tb_complete_stage.sv
// Self-checking bench for complete_stage: directed scenarios plus random
// traffic, checked against a queue-based program-order model.
`timescale 1ns/1ps
module tb_complete_stage;
    import complete_stage_pkg::*;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        rob_row_struct row;
        bit            done;
    } model_entry_t;

    logic clk = 1'b0;
    logic rst;

    complete_stage_if bus ();

    complete_stage #(.ROB_DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    model_entry_t rob_m [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rob_row_struct mk_row(input logic rw, input logic mw,
                                             input logic [5:0] p, input logic [31:0] d);
        rob_row_struct r;
        r.valid       = 1'b1;
        r.RegWrite    = rw;
        r.MemWrite    = mw;
        r.PRegAddrDst = p;
        r.data        = d;
        return r;
    endfunction

    task automatic set_idle();
        for (int s = 0; s < 2; s++) bus.i_rob_row[s] = '0;
        for (int i = 0; i < 3; i++) bus.i_complete_result[i] = '0;
    endtask

    task automatic set_res(input int i, input logic [5:0] p, input logic [31:0] d);
        bus.i_complete_result[i].valid       = 1'b1;
        bus.i_complete_result[i].PRegAddrDst = p;
        bus.i_complete_result[i].data        = d;
    endtask

    // Predict this edge from the model, advance the model, then compare
    task automatic step();
        rob_row_struct        exp_ret [2];
        rob_row_struct        exp_cmp [3];
        int                   hit [3];
        int                   n_ret;
        complete_stage_struct r;
        model_entry_t         e;
        for (int i = 0; i < 2; i++) exp_ret[i] = '0;
        for (int i = 0; i < 3; i++) exp_cmp[i] = '0;
        n_ret = 0;
        if (rob_m.size() > 0 && rob_m[0].done) begin
            exp_ret[0] = rob_m[0].row; exp_ret[0].valid = 1'b1; n_ret = 1;
            if (rob_m.size() > 1 && rob_m[1].done) begin
                exp_ret[1] = rob_m[1].row; exp_ret[1].valid = 1'b1; n_ret = 2;
            end
        end
        for (int i = 0; i < 3; i++) begin
            hit[i] = -1;
            r = bus.i_complete_result[i];
            if (r.valid) begin
                for (int j = 0; j < rob_m.size(); j++) begin
                    if (!rob_m[j].done && rob_m[j].row.PRegAddrDst == r.PRegAddrDst) begin
                        hit[i] = j;
                        break;
                    end
                end
            end
            for (int k = 0; k < i; k++) if (hit[i] >= 0 && hit[k] == hit[i]) hit[i] = -1;
        end
        for (int i = 0; i < 3; i++) begin
            if (hit[i] >= 0) begin
                r = bus.i_complete_result[i];
                rob_m[hit[i]].done     = 1'b1;
                rob_m[hit[i]].row.data = r.data;
                exp_cmp[i]             = rob_m[hit[i]].row;
                exp_cmp[i].valid       = 1'b1;
            end
        end
        for (int n = 0; n < n_ret; n++) void'(rob_m.pop_front());
        for (int s = 0; s < 2; s++) begin
            if (bus.i_rob_row[s].valid && rob_m.size() < int'(DEPTH)) begin
                e.row  = bus.i_rob_row[s];
                e.done = 1'b0;
                rob_m.push_back(e);
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("cmp%0d.valid", i), 64'(bus.o_complete_rob_rows[i].valid), 64'(exp_cmp[i].valid));
            if (exp_cmp[i].valid)
                check($sformatf("cmp%0d.row", i), 64'(bus.o_complete_rob_rows[i]), 64'(exp_cmp[i]));
        end
        for (int s = 0; s < 2; s++) begin
            check($sformatf("ret%0d.valid", s), 64'(bus.o_retire_rob_rows[s].valid), 64'(exp_ret[s].valid));
            if (exp_ret[s].valid)
                check($sformatf("ret%0d.row", s), 64'(bus.o_retire_rob_rows[s]), 64'(exp_ret[s]));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s.cmp%0d", tag, i), 64'(bus.o_complete_rob_rows[i]), 64'd0);
        for (int s = 0; s < 2; s++)
            check($sformatf("%s.ret%0d", tag, s), 64'(bus.o_retire_rob_rows[s]), 64'd0);
    endtask

    // Assert reset mid-cycle with whatever traffic the caller left driven
    task automatic reset_mid();
        #2 rst = 1'b1;
        #1 check_outputs_zero("rst.async");
        @(posedge clk);
        #1 check_outputs_zero("rst.hold");
        set_idle();
        rob_m.delete();
        #2 rst = 1'b0;
    endtask

    // Complete outstanding rows until the model ROB is empty (bounded)
    task automatic drain();
        int guard;
        int used;
        guard = 0;
        while (rob_m.size() > 0 && guard < 8 * int'(DEPTH)) begin
            set_idle();
            used = 0;
            for (int j = 0; j < rob_m.size() && used < 3; j++) begin
                if (!rob_m[j].done) begin
                    set_res(used, rob_m[j].row.PRegAddrDst, $urandom);
                    used++;
                end
            end
            step();
            guard++;
        end
        set_idle();
        if (rob_m.size() != 0) check("drain.bound", 64'(rob_m.size()), 64'd0);
    endtask

    initial begin
        logic [5:0] p;
        int         sz;

        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("reset");
        #2 rst = 1'b0;

        // Dual in-order retire
        set_idle();
        bus.i_rob_row[0] = mk_row(1'b1, 1'b0, 6'd5, 32'hdead);
        bus.i_rob_row[1] = mk_row(1'b1, 1'b0, 6'd6, 32'hbeef);
        step();
        set_idle();
        set_res(0, 6'd5, 32'h11);
        set_res(1, 6'd6, 32'h22);
        step();
        check("dual.cmp0.data", 64'(bus.o_complete_rob_rows[0].data), 64'h11);
        check("dual.cmp1.data", 64'(bus.o_complete_rob_rows[1].data), 64'h22);
        set_idle();
        step();
        check("dual.ret0.data", 64'(bus.o_retire_rob_rows[0].data), 64'h11);
        check("dual.ret1.data", 64'(bus.o_retire_rob_rows[1].data), 64'h22);

        // Out-of-order completion
        bus.i_rob_row[0] = mk_row(1'b1, 1'b0, 6'd7, 32'h0);
        bus.i_rob_row[1] = mk_row(1'b1, 1'b0, 6'd8, 32'h0);
        step();
        set_idle();
        set_res(1, 6'd8, 32'h88);
        step();
        set_idle();
        step();
        check("ooo.hold", 64'(bus.o_retire_rob_rows[0].valid), 64'd0);
        set_res(0, 6'd7, 32'h77);
        step();
        check("ooo.hold2", 64'(bus.o_retire_rob_rows[0].valid), 64'd0);
        set_idle();
        step();
        check("ooo.ret0.preg", 64'(bus.o_retire_rob_rows[0].PRegAddrDst), 64'd7);
        check("ooo.ret1.preg", 64'(bus.o_retire_rob_rows[1].PRegAddrDst), 64'd8);

        // Store retire
        bus.i_rob_row[0] = mk_row(1'b0, 1'b1, 6'd3, 32'h0);
        step();
        set_idle();
        set_res(2, 6'd3, 32'h100);
        step();
        set_idle();
        step();
        check("store.mw",   64'(bus.o_retire_rob_rows[0].MemWrite), 64'd1);
        check("store.data", 64'(bus.o_retire_rob_rows[0].data), 64'h100);
        check("store.preg", 64'(bus.o_retire_rob_rows[0].PRegAddrDst), 64'd3);

        // Full boundary and tail wrap
        for (int c = 0; c < int'(DEPTH) / 2; c++) begin
            bus.i_rob_row[0] = mk_row(1'b1, 1'b0, 6'(10 + 2 * c), 32'h0);
            bus.i_rob_row[1] = mk_row(1'b1, 1'b0, 6'(11 + 2 * c), 32'h0);
            step();
        end
        bus.i_rob_row[0] = mk_row(1'b1, 1'b0, 6'd30, 32'h0);
        bus.i_rob_row[1] = mk_row(1'b1, 1'b0, 6'd31, 32'h0);
        step();
        set_idle();
        set_res(0, 6'd30, 32'h30);
        step();
        check("full.drop", 64'(bus.o_complete_rob_rows[0].valid), 64'd0);
        set_res(0, 6'd10, 32'ha0);
        set_res(1, 6'd11, 32'ha1);
        step();
        set_idle();
        bus.i_rob_row[0] = mk_row(1'b1, 1'b0, 6'd40, 32'h0);
        bus.i_rob_row[1] = mk_row(1'b1, 1'b0, 6'd41, 32'h0);
        step();
        check("full.ret", 64'(bus.o_retire_rob_rows[1].valid), 64'd1);
        set_idle();
        set_res(0, 6'd40, 32'h40);
        step();
        check("full.reuse", 64'(bus.o_complete_rob_rows[0].valid), 64'd1);
        drain();

        // Unmatched and duplicate completions
        bus.i_rob_row[0] = mk_row(1'b1, 1'b0, 6'd20, 32'h0);
        bus.i_rob_row[1] = mk_row(1'b1, 1'b0, 6'd20, 32'h0);
        step();
        set_idle();
        set_res(0, 6'd20, 32'haaaa);
        set_res(1, 6'd50, 32'h5050);
        set_res(2, 6'd20, 32'hbbbb);
        step();
        check("dup.idx0", 64'(bus.o_complete_rob_rows[0].valid), 64'd1);
        check("unmatched", 64'(bus.o_complete_rob_rows[1].valid), 64'd0);
        check("dup.idx2", 64'(bus.o_complete_rob_rows[2].valid), 64'd0);
        set_idle();
        step();
        check("dup.ret0.data", 64'(bus.o_retire_rob_rows[0].data), 64'haaaa);
        check("dup.ret1.none", 64'(bus.o_retire_rob_rows[1].valid), 64'd0);
        drain();

        // Reset with traffic active, then first dispatch right after release
        bus.i_rob_row[0] = mk_row(1'b1, 1'b0, 6'd1, 32'h0);
        bus.i_rob_row[1] = mk_row(1'b1, 1'b0, 6'd2, 32'h0);
        step();
        set_res(0, 6'd1, 32'h1);
        step();
        set_res(0, 6'd2, 32'h2);
        reset_mid();
        step();
        step();
        check("post_rst.idle", 64'(bus.o_retire_rob_rows[0].valid), 64'd0);
        bus.i_rob_row[0] = mk_row(1'b1, 1'b0, 6'd9, 32'h0);
        step();
        set_idle();
        set_res(0, 6'd9, 32'h99);
        step();
        check("post_rst.accept", 64'(bus.o_complete_rob_rows[0].valid), 64'd1);
        set_idle();
        step();

        // Random traffic with one mid-run reset
        for (int c = 0; c < 1500; c++) begin
            set_idle();
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 1) == 1)
                    bus.i_rob_row[s] = mk_row(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                              6'($urandom_range(0, 7)), $urandom);
            end
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 9) < 6) begin
                    sz = rob_m.size();
                    if (sz > 0 && $urandom_range(0, 3) != 0)
                        p = rob_m[$urandom_range(0, sz - 1)].row.PRegAddrDst;
                    else
                        p = 6'($urandom_range(0, 63));
                    set_res(i, p, $urandom);
                end
            end
            if (c == 700) reset_mid();
            else step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
